// File: rtl/px_skip_cfg_if.sv
// rtl/px_skip_cfg_if.sv - skip-field bundle driven by px_skip_cfg
interface px_skip_if;
  logic [15:0] px_to_skip;
  logic [15:0] px_skip_interval;
  logic [15:0] add_px_skip_interval;
  logic [15:0] ln_to_skip;
  logic [15:0] ln_skip_interval;
  logic [15:0] add_ln_skip_interval;

  modport master (
    output px_to_skip, px_skip_interval, add_px_skip_interval,
    output ln_to_skip, ln_skip_interval, add_ln_skip_interval
  );

  modport slave (
    input px_to_skip, px_skip_interval, add_px_skip_interval,
    input ln_to_skip, ln_skip_interval, add_ln_skip_interval
  );
endinterface

// File: rtl/px_skip_cfg.sv
// rtl/px_skip_cfg.sv - frame-scaling skip configurator with a shared 16-cycle divider
// Optional macro PX_SKIP_CFG_SOF_SYNC_EN holds results until the next start-of-frame.
module px_skip_cfg (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cfg_valid_i,
  input  logic [15:0] in_width_i,
  input  logic [15:0] in_height_i,
  input  logic [15:0] out_width_i,
  input  logic [15:0] out_height_i,
  input  logic        sof_i,
  output logic        busy_o,
  output logic        cfg_err_o,
  px_skip_if.master   skip_if
);

`ifdef PX_SKIP_CFG_SOF_SYNC_EN
  typedef enum logic [2:0] {IDLE, CHECK, PX_DIV, LN_DIV, PENDING} state_t;
`else
  typedef enum logic [2:0] {IDLE, CHECK, PX_DIV, LN_DIV} state_t;
`endif

  state_t state, state_nxt;

  logic [15:0] in_w, in_h, out_w, out_h;
  logic [15:0] s_px, s_ln;
  logic        bad_req;
  logic [3:0]  cnt;
  logic        last;

  // Restoring divider: acc holds the partial remainder, dq shifts the
  // dividend out and the quotient in, dv is the divisor.
  logic [15:0] acc, dq, dv;
  logic [16:0] trial, diff;
  logic        ge;
  logic [15:0] acc_nxt, dq_nxt;
  logic [15:0] q_res, r_res;

  logic [15:0] sh_px_q, sh_px_r;
`ifdef PX_SKIP_CFG_SOF_SYNC_EN
  logic [15:0] sh_ln_q, sh_ln_r;
`else
  logic        unused_sof;
  assign unused_sof = sof_i;
`endif

  assign s_px    = in_w - out_w;
  assign s_ln    = in_h - out_h;
  assign bad_req = (out_w == 16'd0) || (out_h == 16'd0) || (out_w > in_w) || (out_h > in_h);
  assign last    = (cnt == 4'd15);
  assign busy_o  = (state != IDLE);

  assign trial   = {acc, dq[15]};
  assign diff    = trial - {1'b0, dv};
  assign ge      = (trial >= {1'b0, dv});
  assign acc_nxt = ge ? diff[15:0] : trial[15:0];
  assign dq_nxt  = {dq[14:0], ge};
  // A zero divisor still runs the full 16 steps; only the result is forced to 0.
  assign q_res   = (dv == 16'd0) ? 16'd0 : dq_nxt;
  assign r_res   = (dv == 16'd0) ? 16'd0 : acc_nxt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_valid_i) state_nxt = CHECK;
      CHECK:   state_nxt = bad_req ? IDLE : PX_DIV;
      PX_DIV:  if (last) state_nxt = LN_DIV;
`ifdef PX_SKIP_CFG_SOF_SYNC_EN
      LN_DIV:  if (last) state_nxt = PENDING;
      PENDING: if (sof_i) state_nxt = IDLE;
`else
      LN_DIV:  if (last) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_w      <= 16'd0;
      in_h      <= 16'd0;
      out_w     <= 16'd0;
      out_h     <= 16'd0;
      cfg_err_o <= 1'b0;
      cnt       <= 4'd0;
      acc       <= 16'd0;
      dq        <= 16'd0;
      dv        <= 16'd0;
      sh_px_q   <= 16'd0;
      sh_px_r   <= 16'd0;
`ifdef PX_SKIP_CFG_SOF_SYNC_EN
      sh_ln_q   <= 16'd0;
      sh_ln_r   <= 16'd0;
`endif
      skip_if.px_to_skip           <= 16'd0;
      skip_if.px_skip_interval     <= 16'd0;
      skip_if.add_px_skip_interval <= 16'd0;
      skip_if.ln_to_skip           <= 16'd0;
      skip_if.ln_skip_interval     <= 16'd0;
      skip_if.add_ln_skip_interval <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid_i) begin
            in_w      <= in_width_i;
            in_h      <= in_height_i;
            out_w     <= out_width_i;
            out_h     <= out_height_i;
            cfg_err_o <= 1'b0;
          end
        end
        CHECK: begin
          if (bad_req) begin
            cfg_err_o <= 1'b1;
          end else begin
            acc <= 16'd0;
            dq  <= in_w;
            dv  <= s_px;
            cnt <= 4'd0;
          end
        end
        PX_DIV: begin
          cnt <= cnt + 4'd1;
          if (last) begin
            sh_px_q <= q_res;
            sh_px_r <= r_res;
            acc     <= 16'd0;
            dq      <= in_h;
            dv      <= s_ln;
          end else begin
            acc <= acc_nxt;
            dq  <= dq_nxt;
          end
        end
        LN_DIV: begin
          cnt <= cnt + 4'd1;
          acc <= acc_nxt;
          dq  <= dq_nxt;
          if (last) begin
`ifdef PX_SKIP_CFG_SOF_SYNC_EN
            sh_ln_q <= q_res;
            sh_ln_r <= r_res;
`else
            skip_if.px_to_skip           <= s_px;
            skip_if.px_skip_interval     <= sh_px_q;
            skip_if.add_px_skip_interval <= sh_px_r;
            skip_if.ln_to_skip           <= s_ln;
            skip_if.ln_skip_interval     <= q_res;
            skip_if.add_ln_skip_interval <= r_res;
`endif
          end
        end
`ifdef PX_SKIP_CFG_SOF_SYNC_EN
        PENDING: begin
          if (sof_i) begin
            skip_if.px_to_skip           <= s_px;
            skip_if.px_skip_interval     <= sh_px_q;
            skip_if.add_px_skip_interval <= sh_px_r;
            skip_if.ln_to_skip           <= s_ln;
            skip_if.ln_skip_interval     <= sh_ln_q;
            skip_if.add_ln_skip_interval <= sh_ln_r;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_px_skip_cfg.sv
// tb/tb_px_skip_cfg.sv - self-checking bench for px_skip_cfg against an arithmetic model
module tb_px_skip_cfg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        sof;
  logic [15:0] iw, ih, ow, oh;
  logic        busy, err;

  always #5 clk = ~clk;

  px_skip_if sif ();

  px_skip_cfg dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .cfg_valid_i  (cfg_valid),
    .in_width_i   (iw),
    .in_height_i  (ih),
    .out_width_i  (ow),
    .out_height_i (oh),
    .sof_i        (sof),
    .busy_o       (busy),
    .cfg_err_o    (err),
    .skip_if      (sif)
  );

`ifdef PX_SKIP_CFG_SOF_SYNC_EN
  localparam int STOP_AT = 33;
`else
  localparam int STOP_AT = 200;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_f [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, ".px_to_skip"},   {16'd0, sif.px_to_skip},           {16'd0, exp_f[0]});
    chk({tag, ".px_interval"},  {16'd0, sif.px_skip_interval},     {16'd0, exp_f[1]});
    chk({tag, ".px_add"},       {16'd0, sif.add_px_skip_interval}, {16'd0, exp_f[2]});
    chk({tag, ".ln_to_skip"},   {16'd0, sif.ln_to_skip},           {16'd0, exp_f[3]});
    chk({tag, ".ln_interval"},  {16'd0, sif.ln_skip_interval},     {16'd0, exp_f[4]});
    chk({tag, ".ln_add"},       {16'd0, sif.add_ln_skip_interval}, {16'd0, exp_f[5]});
  endtask

  task automatic axis_model(input logic [15:0] a_in, input logic [15:0] a_out,
                            output logic [15:0] s, output logic [15:0] q, output logic [15:0] r);
    s = a_in - a_out;
    if (s == 16'd0) begin
      q = 16'd0;
      r = 16'd0;
    end else begin
      q = a_in / s;
      r = a_in % s;
    end
  endtask

  task automatic run_req(input logic [15:0] r_iw, input logic [15:0] r_ih,
                         input logic [15:0] r_ow, input logic [15:0] r_oh, input bit poke);
    logic [15:0] nf [6];
    bit bad;
    int n;
    bad = (r_ow == 0) || (r_oh == 0) || (r_ow > r_iw) || (r_oh > r_ih);
    axis_model(r_iw, r_ow, nf[0], nf[1], nf[2]);
    axis_model(r_ih, r_oh, nf[3], nf[4], nf[5]);
    @(negedge clk);
    iw = r_iw; ih = r_ih; ow = r_ow; oh = r_oh; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("err_clear_on_accept", {31'd0, err}, 32'd0);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    if (bad) begin
      @(negedge clk);
      chk("err_busy_low", {31'd0, busy}, 32'd0);
      chk("err_set", {31'd0, err}, 32'd1);
      chk_fields("err_unchanged");
      return;
    end
    n = 0;
    while (busy === 1'b1 && n < STOP_AT) begin
      n++;
      if (poke && n == 5) begin
        cfg_valid = 1'b1; iw = 16'd50; ih = 16'd40; ow = 16'd10; oh = 16'd10;
      end
      if (n == 6) cfg_valid = 1'b0;
`ifdef PX_SKIP_CFG_SOF_SYNC_EN
      if (n == 5) sof = 1'b1;
      if (n == 6) sof = 1'b0;
`endif
      if (n == 20) chk_fields("no_partial");
      @(negedge clk);
    end
    chk("busy_cycles", n, 33);
`ifdef PX_SKIP_CFG_SOF_SYNC_EN
    chk("pending_busy", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    chk_fields("pending_hold");
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
`endif
    exp_f = nf;
    chk_fields("result");
    chk("done_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("strobe_ignored", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] a, b, c, d;
    int mode;
    rst_n = 1'b0; cfg_valid = 1'b0; sof = 1'b0;
    iw = '0; ih = '0; ow = '0; oh = '0;
    foreach (exp_f[k]) exp_f[k] = 16'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk_fields("reset");
    rst_n = 1'b1;

    run_req(16'd1920, 16'd1080, 16'd1280, 16'd720, 1'b1);
    run_req(16'd1920, 16'd1080, 16'd1000, 16'd1080, 1'b0);
    run_req(16'd1920, 16'd1080, 16'd2000, 16'd720, 1'b0);
    run_req(16'd1920, 16'd1080, 16'd1280, 16'd720, 1'b0);
    run_req(16'd1920, 16'd1080, 16'd1280, 16'd0, 1'b0);
    run_req(16'd65535, 16'd65535, 16'd1, 16'd65535, 1'b1);

    // Reset in the middle of the pixel division
    @(negedge clk);
    iw = 16'd800; ih = 16'd600; ow = 16'd400; oh = 16'd300; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    foreach (exp_f[k]) exp_f[k] = 16'd0;
    chk_fields("mid_reset");
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    chk("mid_reset_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk_fields("after_reset_idle");
    chk("after_reset_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom_range(1, 65535));
      b = 16'($urandom_range(1, 65535));
      mode = int'($urandom_range(0, 4));
      case (mode)
        0:       c = (a == 16'hFFFF) ? 16'd0 : a + 16'd1;
        1:       c = a;
        default: c = 16'($urandom_range(1, a));
      endcase
      d = (mode == 1) ? 16'($urandom_range(1, b)) : ((mode == 2) ? b : 16'($urandom_range(1, b)));
      run_req(a, b, c, d, i[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/px_skip_cfg.md
PX_SKIP_CFG -- requirements
Module: px_skip_cfg

Interface
REQ-001 SHALL have no parameters; all fields are fixed at 16 bits to match px_skip_if.
REQ-002 SHALL have port clk_i, input, 1, single clock for all logic.
REQ-003 SHALL have port rst_n_i, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port cfg_valid_i, input, 1, request strobe for a new configuration.
REQ-005 SHALL have ports in_width_i and in_height_i, input, 16 each, source frame size.
REQ-006 SHALL have ports out_width_i and out_height_i, input, 16 each, target frame size.
REQ-007 SHALL have port sof_i, input, 1, start-of-frame pulse from the video stream.
REQ-008 SHALL have port busy_o, output, 1, high while a request is in progress.
REQ-009 SHALL have port cfg_err_o, output, 1, sticky flag marking an invalid request.
REQ-010 SHALL have port skip_if, px_skip_if.master, which drives all six skip fields.

Function
REQ-011 SHALL accept cfg_valid_i only in IDLE; on the accepting edge it SHALL capture all four size inputs and enter CHECK. cfg_valid_i in any other state SHALL be ignored.
REQ-012 SHALL spend one cycle in CHECK: if out_width or out_height is 0, or out > in on either axis, it SHALL set cfg_err_o, leave all skip fields unchanged and return to IDLE.
REQ-013 SHALL clear cfg_err_o on the accepting edge of the next request.
REQ-014 SHALL compute S_px = in_width - out_width and S_ln = in_height - out_height as 16-bit unsigned values.
REQ-015 In PX_DIV (exactly 16 cycles), one shared 16-bit restoring divider SHALL compute q = in_width / S_px and r = in_width mod S_px.
REQ-016 LN_DIV (exactly 16 cycles) SHALL then do the same for in_height and S_ln.
REQ-017 If S = 0 on an axis, the quotient and remainder SHALL be 0 for that axis, and the state SHALL still last 16 cycles so latency is fixed.
REQ-018 Result mapping: px_to_skip = S_px, px_skip_interval = q_px, add_px_skip_interval = r_px; the line fields map the same way.
REQ-019 Results SHALL be held in shadow registers. The six skip_if outputs SHALL update together in one edge and never show a mix of old and new values.
REQ-020 busy_o SHALL be high from the edge after acceptance until the edge on which the outputs update, or until the return from CHECK on error.
REQ-021 The FSM states SHALL be IDLE, CHECK, PX_DIV, LN_DIV and PENDING. PENDING exists only with the macro in REQ-024.

Reset
REQ-022 While rst_n_i is low: FSM in IDLE, all six skip fields 0, busy_o = 0, cfg_err_o = 0, shadow and divider registers 0.
REQ-023 Reset asserted mid-computation SHALL abort the request; the outputs SHALL NOT take partial results.

Configuration
REQ-024 Macro PX_SKIP_CFG_SOF_SYNC_EN defined: after LN_DIV the FSM SHALL enter PENDING and wait there with busy_o high. Outputs SHALL update on the first edge where sof_i = 1 in PENDING, and the FSM SHALL then return to IDLE. A sof_i seen during PX_DIV or LN_DIV SHALL be ignored.
REQ-025 Macro not defined: outputs SHALL update on the edge that ends LN_DIV; sof_i SHALL be unused; busy_o SHALL be high for exactly 33 cycles (1 + 16 + 16).

Verification
REQ-026 Request 1920x1080 -> 1280x720, no macro -> px_to_skip = 640, interval = 3, add = 0; ln_to_skip = 360, interval = 3, add = 0; busy_o high for 33 cycles.
REQ-027 Request 1920x1080 -> 1000x1080 -> px fields 920/2/80; ln fields 0/0/0.
REQ-028 Request out_width = 2000 with in_width = 1920 -> cfg_err_o = 1 after 1 cycle, fields unchanged. The next valid request clears cfg_err_o.
REQ-029 Macro defined, valid request, sof_i pulsed 10 cycles after LN_DIV ends -> fields change on the sof_i edge only. An earlier sof_i during PX_DIV has no effect.
REQ-030 Pulse rst_n_i low mid-PX_DIV, then pulse cfg_valid_i during busy -> all outputs 0 immediately; the strobe during busy is ignored.
